// File: rtl/matrix_fetch_ctrl.sv
// Operand fetch sequencer: streams W then X from a fixed-latency, non-pipelined memory
// into the operand buffers, one outstanding read at a time.
module matrix_fetch_ctrl #(
    parameter int unsigned N              = 4,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned BANKING_FACTOR = 1,
    parameter int unsigned ADDRESS_WIDTH  = 13,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_W = 13'h0000,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_X = 13'h1000,
    parameter int unsigned MEM_LATENCY    = 2,
    localparam int unsigned IDX_W         = (N * N > 1) ? $clog2(N * N) : 1,
    localparam int unsigned WORD_W        = DATA_WIDTH * BANKING_FACTOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     w_en,
    input  logic                     x_en,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_read_en,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    output logic                     mem_write_en,
    output logic [WORD_W-1:0]        mem_req_data,
    input  logic [WORD_W-1:0]        mem_resp_data,
    output logic                     buf_wr_en,
    output logic                     buf_sel,
    output logic [IDX_W-1:0]         buf_wr_idx,
    output logic [WORD_W-1:0]        buf_wr_data
);

    localparam int unsigned BEATS  = N * N / BANKING_FACTOR;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned STRIDE = BANKING_FACTOR * DATA_WIDTH / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StDone} state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                sel_q, sel_d;
    logic                x_q, x_d;

    logic [ADDRESS_WIDTH-1:0] base_addr;
    logic [ADDRESS_WIDTH-1:0] beat_addr;
    logic [IDX_W-1:0]         beat_idx;

    assign base_addr    = sel_q ? BASE_ADDR_X : BASE_ADDR_W;
    assign beat_addr    = base_addr + ADDRESS_WIDTH'(32'(beat_q) * STRIDE);
    assign beat_idx     = IDX_W'(32'(beat_q) * BANKING_FACTOR);
    assign mem_write_en = 1'b0;
    assign mem_req_data = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            lat_q   <= '0;
            sel_q   <= 1'b0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        sel_d        = sel_q;
        x_d          = x_q;
        busy         = 1'b0;
        done         = 1'b0;
        mem_read_en  = 1'b0;
        mem_req_addr = '0;
        buf_wr_en    = 1'b0;
        buf_sel      = 1'b0;
        buf_wr_idx   = '0;
        buf_wr_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (w_en || x_en) begin
                        x_d     = x_en;
                        sel_d   = ~w_en;
                        beat_d  = '0;
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                busy         = 1'b1;
                mem_read_en  = 1'b1;
                mem_req_addr = beat_addr;
                lat_d        = '0;
                state_d      = (MEM_LATENCY == 0) ? StCapture : StWait;
            end
            StWait: begin
                busy = 1'b1;
                if (lat_q == LAST_LAT) begin
                    state_d = StCapture;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StCapture: begin
                busy        = 1'b1;
                buf_wr_en   = 1'b1;
                buf_sel     = sel_q;
                buf_wr_idx  = beat_idx;
                buf_wr_data = mem_resp_data;
                if (beat_q != LAST_BEAT) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = StIssue;
                end else if (!sel_q && x_q) begin
                    // W finished, roll straight into X
                    sel_d   = 1'b1;
                    beat_d  = '0;
                    state_d = StIssue;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_matrix_fetch_ctrl.sv
// Scoreboard bench: two DUTs (banking 1 and 2) with latency-2 mock memories; every cycle's
// full output vector is checked against events queued when each start is issued.
module tb_matrix_fetch_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd;
        logic [12:0] addr;
        logic        wr;
        logic        sel;
        logic [3:0]  idx;
        logic [31:0] data;
        logic        wen;
        logic [31:0] wdata;
    } obs_t;

    typedef struct {
        int   cyc;
        int   d;
        obs_t o;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] w_en = '0;
    logic [1:0] x_en = '0;

    logic        busy0, done0, rd0, wen0, wr0, sel0;
    logic [12:0] addr0;
    logic [15:0] wdata0, resp0, data0;
    logic [3:0]  idx0;
    logic        busy1, done1, rd1, wen1, wr1, sel1;
    logic [12:0] addr1;
    logic [31:0] wdata1, resp1, data1;
    logic [3:0]  idx1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    ev_t  evq[$];

    logic [15:0] pipe0 [3];
    logic [31:0] pipe1 [3];

    matrix_fetch_ctrl #(.BANKING_FACTOR(1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .w_en(w_en[0]), .x_en(x_en[0]),
        .busy(busy0), .done(done0), .mem_read_en(rd0), .mem_req_addr(addr0),
        .mem_write_en(wen0), .mem_req_data(wdata0), .mem_resp_data(resp0),
        .buf_wr_en(wr0), .buf_sel(sel0), .buf_wr_idx(idx0), .buf_wr_data(data0)
    );

    matrix_fetch_ctrl #(.BANKING_FACTOR(2)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .w_en(w_en[1]), .x_en(x_en[1]),
        .busy(busy1), .done(done1), .mem_read_en(rd1), .mem_req_addr(addr1),
        .mem_write_en(wen1), .mem_req_data(wdata1), .mem_resp_data(resp1),
        .buf_wr_en(wr1), .buf_sel(sel1), .buf_wr_idx(idx1), .buf_wr_data(data1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input int d, input logic [12:0] a);
        if (d == 1) return {3'b110, a, 3'b011, a};
        return {16'h0000, 3'b101, a};
    endfunction

    // Mock memory: data appears MEM_LATENCY+1 = 3 cycles after the read_en cycle.
    always @(posedge clk) begin
        pipe0[0] <= rd0 ? 16'(mem_word(0, addr0)) : 16'h0;
        pipe0[1] <= pipe0[0];
        pipe0[2] <= pipe0[1];
        pipe1[0] <= rd1 ? mem_word(1, addr1) : 32'h0;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign resp0 = pipe0[2];
    assign resp1 = pipe1[2];

    function automatic obs_t mk(input bit b, input bit dn, input bit rd, input logic [12:0] a,
                                input bit wr, input bit sel, input logic [3:0] idx,
                                input logic [31:0] dat);
        obs_t o;
        o = '0;
        o.busy = b;
        o.done = dn;
        o.rd   = rd;
        o.addr = a;
        o.wr   = wr;
        o.sel  = sel;
        o.idx  = idx;
        o.data = dat;
        return o;
    endfunction

    function automatic void add(input int d, input int c, input int lim, input obs_t o);
        ev_t e;
        if (c > lim) return;
        e.cyc = c;
        e.d   = d;
        e.o   = o;
        evq.push_back(e);
    endfunction

    // Queue the expected per-cycle outputs for a run whose start is sampled at the end of s.
    function automatic void push_run(input int d, input int s, input bit w, input bit x,
                                     input int lim);
        int bf = (d == 1) ? 2 : 1;
        int c  = s + 1;
        logic [12:0] a;
        for (int m = 0; m < 2; m++) begin
            if ((m == 0 && w) || (m == 1 && x)) begin
                for (int k = 0; k < 16 / bf; k++) begin
                    a = 13'((m == 1 ? 32'h1000 : 32'h0) + k * 2 * bf);
                    add(d, c, lim, mk(1, 0, 1, a, 0, 0, 4'h0, 32'h0));
                    add(d, c + 1, lim, mk(1, 0, 0, 13'h0, 0, 0, 4'h0, 32'h0));
                    add(d, c + 2, lim, mk(1, 0, 0, 13'h0, 0, 0, 4'h0, 32'h0));
                    add(d, c + 3, lim, mk(1, 0, 0, 13'h0, 1, m[0], 4'(k * bf), mem_word(d, a)));
                    c += 4;
                end
            end
        end
        add(d, c, lim, mk(1, 1, 0, 13'h0, 0, 0, 4'h0, 32'h0));
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                obs_t act, exp_o;
                if (d == 0)
                    act = {busy0, done0, rd0, addr0, wr0, sel0, idx0, 16'h0, data0,
                           wen0, 16'h0, wdata0};
                else
                    act = {busy1, done1, rd1, addr1, wr1, sel1, idx1, data1, wen1, wdata1};
                exp_o = '0;
                if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].d == d) begin
                    ev_t e;
                    e = evq.pop_front();
                    exp_o = e.o;
                end
                n_cmp++;
                if (act !== exp_o) begin
                    n_bad++;
                    $display("FAIL outputs dut%0d cycle %0d: got %h required %h",
                             d, cyc, act, exp_o);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input int d, input bit w, input bit x, input int lim_off, output int s);
        s = cyc;
        start[d] = 1'b1;
        w_en[d]  = w;
        x_en[d]  = x;
        push_run(d, s, w, x, s + lim_off);
        @(posedge clk);
        #1;
        start = '0;
        w_en  = '0;
        x_en  = '0;
    endtask

    initial begin
        int s;
        int big = 1000;
        wait_cyc(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_cyc(10);

        go(0, 1, 0, big, s);                 // W only
        wait_cyc(s + 70);
        go(0, 1, 1, big, s);                 // W then X
        wait_cyc(s + 135);
        go(1, 1, 1, big, s);                 // banking factor 2
        wait_cyc(s + 70);
        go(0, 0, 1, big, s);                 // X only
        wait_cyc(s + 70);

        go(0, 1, 0, big, s);                 // start during a run is dropped
        wait_cyc(s + 20);
        start[0] = 1'b1;
        w_en[0]  = 1'b1;
        x_en[0]  = 1'b1;
        @(posedge clk);
        #1;
        start = '0;
        w_en  = '0;
        x_en  = '0;
        wait_cyc(s + 70);

        go(0, 0, 0, big, s);                 // empty start
        wait_cyc(s + 5);

        go(0, 1, 0, 22, s);                  // reset in a WAIT cycle of beat 5
        wait_cyc(s + 22);
        rst = 1'b1;
        wait_cyc(s + 23);
        rst = 1'b0;
        wait_cyc(s + 30);
        go(0, 1, 0, big, s);
        wait_cyc(s + 70);

        mon_en = 1'b0;
        n_cmp++;
        if (evq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected events left, required 0", evq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
